// File: rtl/alu_response_misr.sv
// alu_response_misr: 32-bit MISR compactor for ALU responses with golden compare; define ALU_MISR_FLAGS_EN to fold status flags into the signature
module alu_response_misr #(
  parameter logic [31:0] SEED    = 32'hFFFF_FFFF,
  parameter logic [31:0] POLY    = 32'h04C1_1DB7,
  parameter int          COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic [31:0]        golden,
  input  logic               in_valid,
  input  logic [31:0]        out,
  input  logic               overflow,
  input  logic               zero,
  input  logic               negative,
  output logic               in_ready,
  output logic [31:0]        signature,
  output logic [COUNT_W-1:0] sample_count,
  output logic               busy,
  output logic               done,
  output logic               pass
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] sig_q, sig_d, gold_q, gold_d, data;
  logic [COUNT_W-1:0] cnt_q, cnt_d, num_q, num_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, rdy_q, rdy_d;
  logic launch, accept, last;
`ifdef ALU_MISR_FLAGS_EN
  assign data = out ^ {overflow, zero, negative, 29'b0};
`else
  logic unused_flags;
  assign unused_flags = overflow ^ zero ^ negative;
  assign data = out;
`endif
  assign launch = start && state_q != RUN;
  assign accept = in_valid && rdy_q;
  assign last = cnt_q == num_q - 1'b1;
  // next-state, signature fold, counters and registered status outputs
  always_comb begin
    state_d = launch ? (num_samples == '0 ? DONE : RUN) : (accept && last) ? DONE : state_q;
    sig_d   = launch ? SEED : accept ? ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data) : sig_q;
    cnt_d   = launch ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
    num_d   = launch ? num_samples : num_q;
    gold_d  = launch ? golden : gold_q;
    busy_d  = state_d == RUN;
    rdy_d   = state_d == RUN;
    done_d  = state_d == DONE;
    pass_d  = state_d == DONE && sig_d == gold_d;
  end
  // all state with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      gold_q  <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      gold_q  <= gold_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign in_ready     = rdy_q;
  assign signature    = sig_q;
  assign sample_count = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
endmodule

// File: tb/tb_alu_response_misr.sv
// tb_alu_response_misr: table, hand-written and randomized checks of alu_response_misr against a polynomial reference model
module tb_alu_response_misr;
`ifdef ALU_MISR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic overflow = 1'b0, zero = 1'b0, negative = 1'b0;
  logic [15:0] num_samples = '0;
  logic [31:0] golden = '0, out = '0;
  logic in_ready, busy, done, pass;
  logic [31:0] signature;
  logic [15:0] sample_count;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    int          n;
    logic [31:0] gold;
    logic [31:0] w;
    logic [2:0]  f;
    logic [31:0] sig;
    logic        pass;
  } vec_t;
  vec_t tbl[5];

  alu_response_misr dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_samples(num_samples),
    .golden(golden), .in_valid(in_valid), .out(out), .overflow(overflow),
    .zero(zero), .negative(negative), .in_ready(in_ready), .signature(signature),
    .sample_count(sample_count), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clock = ~clock;

  // signature after one word: multiply by x modulo the full 33-bit polynomial, then add the data word
  function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] w, input logic [2:0] f);
    logic [32:0] t;
    t = {s, 1'b0};
    if (t[32]) t = t ^ {1'b1, POLY};
    return t[31:0] ^ w ^ (FLAGS ? {f, 29'b0} : 32'h0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_run(input int n, input logic [31:0] g);
    start = 1'b1;
    num_samples = 16'(n);
    golden = g;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic [2:0] f, input int gaps);
    repeat (gaps) @(negedge clock);
    in_valid = 1'b1;
    out = w;
    {overflow, zero, negative} = f;
    @(negedge clock);
    in_valid = 1'b0;
    {overflow, zero, negative} = 3'b0;
  endtask

  initial begin
    logic [31:0] exp_sig, g;
    logic [31:0] words[$];
    logic [2:0] flg[$];
    int n;
    tbl[0] = '{1, 32'hFB3E_E249, 32'h0, 3'b000, 32'hFB3E_E249, 1'b1};
    tbl[1] = '{1, 32'hFB3E_E249, 32'h0, 3'b110, FLAGS ? 32'h3B3E_E249 : 32'hFB3E_E249, !FLAGS};
    tbl[2] = '{1, 32'h0, 32'hFFFF_FFFF, 3'b000, 32'h04C1_1DB6, 1'b0};
    tbl[3] = '{1, 32'h04C1_1DB6, 32'hFFFF_FFFF, 3'b001, FLAGS ? 32'h24C1_1DB6 : 32'h04C1_1DB6, !FLAGS};
    tbl[4] = '{0, 32'hFFFF_FFFF, 32'h0, 3'b000, 32'hFFFF_FFFF, 1'b1};
    repeat (2) @(negedge clock);
    check("reset_sig", signature, SEED);
    check("reset_cnt", 32'(sample_count), 0);
    check("reset_flags", {busy, done, pass, in_ready}, 0);
    reset_n = 1'b1;
    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    out = 32'h1234_5678;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    check("idle_valid_sig", signature, SEED);
    check("idle_valid_cnt", 32'(sample_count), 0);
    check("idle_valid_busy", {busy, in_ready}, 0);
    // table-driven single-sample and zero-length runs
    for (int i = 0; i < 5; i++) begin
      start_run(tbl[i].n, tbl[i].gold);
      if (tbl[i].n > 0) begin
        check($sformatf("t%0d_running", i), {busy, in_ready, done, pass}, 4'b1100);
        send(tbl[i].w, tbl[i].f, 0);
      end else
        check($sformatf("t%0d_no_ready", i), 32'(in_ready), 0);
      check($sformatf("t%0d_sig", i), signature, tbl[i].sig);
      check($sformatf("t%0d_pass", i), 32'(pass), 32'(tbl[i].pass));
      check($sformatf("t%0d_done", i), {busy, done}, 2'b01);
      check($sformatf("t%0d_cnt", i), 32'(sample_count), 32'(tbl[i].n));
    end
    // in_valid in DONE is ignored
    in_valid = 1'b1;
    out = 32'hDEAD_BEEF;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    check("done_valid_sig", signature, SEED);
    check("done_valid_state", {done, pass, 16'(sample_count)}, {2'b11, 16'd0});
    // valid gaps: three zero words with two idle cycles before each
    exp_sig = fold(fold(fold(SEED, 0, 0), 0, 0), 0, 0);
    start_run(3, exp_sig);
    send(0, 0, 2);
    send(0, 0, 2);
    check("gap_not_done", {done, busy}, 2'b01);
    send(0, 0, 2);
    check("gap_sig", signature, exp_sig);
    check("gap_cnt", 32'(sample_count), 3);
    check("gap_done_pass", {done, pass}, 2'b11);
    // start pulsed mid-run is ignored
    words = {32'h1, 32'h2, 32'h3, 32'h4};
    exp_sig = SEED;
    foreach (words[k]) exp_sig = fold(exp_sig, words[k], 0);
    start_run(4, exp_sig);
    send(words[0], 0, 0);
    g = signature;
    start_run(1, 32'h0);
    check("midstart_sig", signature, fold(SEED, words[0], 0));
    check("midstart_cnt", 32'(sample_count), 1);
    check("midstart_busy", {busy, done}, 2'b10);
    send(words[1], 0, 0);
    send(words[2], 0, 0);
    check("midstart_not_done", 32'(done), 0);
    send(words[3], 0, 0);
    check("midstart_final", {done, pass, 16'(sample_count)}, {2'b11, 16'd4});
    check("midstart_end_sig", signature, exp_sig);
    // asynchronous reset after two accepts of a five-sample run
    start_run(5, 32'h0);
    send(32'hA5A5_A5A5, 3'b111, 0);
    send(32'h5A5A_5A5A, 3'b010, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_sig", signature, SEED);
    check("rst_mid_cnt", 32'(sample_count), 0);
    check("rst_mid_flags", {busy, done, pass, in_ready}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_after_idle", {busy, done}, 0);
    exp_sig = fold(fold(SEED, 32'hCAFE_F00D, 3'b100), 32'h0BAD_0BAD, 3'b011);
    start_run(2, exp_sig);
    send(32'hCAFE_F00D, 3'b100, 0);
    send(32'h0BAD_0BAD, 3'b011, 0);
    check("rst_rerun_sig", signature, exp_sig);
    check("rst_rerun_state", {done, pass, 16'(sample_count)}, {2'b11, 16'd2});
    // randomized runs against the model
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 12);
      words.delete();
      flg.delete();
      exp_sig = SEED;
      for (int k = 0; k < n; k++) begin
        words.push_back($urandom);
        flg.push_back(3'($urandom));
        exp_sig = fold(exp_sig, words[k], flg[k]);
      end
      g = $urandom_range(0, 1) ? exp_sig : $urandom;
      start_run(n, g);
      check($sformatf("r%0d_start", r), {busy, done, pass}, 3'b100);
      exp_sig = SEED;
      for (int k = 0; k < n; k++) begin
        send(words[k], flg[k], $urandom_range(0, 2));
        exp_sig = fold(exp_sig, words[k], flg[k]);
        check($sformatf("r%0d_s%0d_sig", r, k), signature, exp_sig);
        check($sformatf("r%0d_s%0d_cnt", r, k), 32'(sample_count), 32'(k + 1));
        check($sformatf("r%0d_s%0d_done", r, k), 32'(done), 32'(k == n - 1));
      end
      check($sformatf("r%0d_pass", r), 32'(pass), 32'(exp_sig == g));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
